// File: rtl/iter_alu.sv
// iter_alu: RV32-style ALU with a handshaked, iterative M-extension unit.
//
// Base ops finish with one registered cycle of latency. Multiply and divide
// run one bit per cycle (WIDTH iterations) on magnitudes, with the sign
// applied on the final iteration. Division by zero and signed overflow skip
// the iterative path and finish with one cycle of latency.
//
// Optional feature macro: ITER_ALU_DIV_EN. When it is defined, the divider
// datapath is built. When it is not defined, ops 10100..10111 return 0 with
// one cycle of latency.
//
// Ports:
//   clk_i    - clock, rising edge
//   rst_i    - asynchronous active-high reset
//   valid_i  - request valid
//   ready_o  - block can accept a request this cycle
//   op_i     - operation select (op_i[4]=1 selects the M ops)
//   a_i, b_i - operands
//   valid_o  - result valid; res_o is held until ready_i
//   ready_i  - consumer accepts the result
//   res_o    - result
//   busy_o   - iterative operation in progress
//
// state | meaning
// IDLE  | waiting for a request
// BUSY  | multiply/divide iterating, one bit per cycle
// DONE  | result valid, held until ready_i
module iter_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [4:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] res_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   hi_q, hi_d;      // partial product high half / remainder
  logic [WIDTH-1:0]   lo_q, lo_d;      // multiplier / dividend-quotient
  logic [WIDTH-1:0]   opnd_q, opnd_d;  // multiplicand / divisor magnitude
  logic [SHW:0]       cnt_q, cnt_d;
  logic [1:0]         mop_q, mop_d;    // op_i[1:0] of the running M op
  logic               neg_q, neg_d;    // negate the result on exit
`ifdef ITER_ALU_DIV_EN
  logic               div_q, div_d;
`endif

  logic               accept;
  logic [WIDTH-1:0]   base_res;

  assign ready_o = (state_q == IDLE) || ((state_q == DONE) && ready_i);
  assign accept  = valid_i && ready_o;
  assign valid_o = (state_q == DONE);
  assign busy_o  = (state_q == BUSY);
  assign res_o   = res_q;

  // Base ALU
  always_comb begin
    base_res = '0;
    case (op_i[3:0])
      4'b0000: base_res = a_i + b_i;
      4'b1100: base_res = a_i - b_i;
      4'b0001: base_res = a_i << b_i[SHW-1:0];
      4'b0101: base_res = a_i >> b_i[SHW-1:0];
      4'b1101: base_res = WIDTH'($signed(a_i) >>> b_i[SHW-1:0]);
      4'b0010: base_res = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      4'b0011: base_res = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
      4'b0100: base_res = a_i ^ b_i;
      4'b0110: base_res = a_i | b_i;
      4'b0111: base_res = a_i & b_i;
      4'b1111: base_res = b_i;
      default: base_res = '0;
    endcase
  end

  // Operand conditioning at capture
  logic             a_sgn, b_sgn, a_neg, b_neg, start_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    if (op_i[2]) begin
      // DIV/REM are signed, DIVU/REMU are not
      a_sgn = ~op_i[0];
      b_sgn = ~op_i[0];
    end else begin
      // MULH and MULHSU treat A as signed; only MULH treats B as signed.
      // MUL takes the low half, which is the same for any signedness.
      a_sgn = (op_i[1:0] == 2'b01) || (op_i[1:0] == 2'b10);
      b_sgn = (op_i[1:0] == 2'b01);
    end
    a_neg = a_sgn & a_i[WIDTH-1];
    b_neg = b_sgn & b_i[WIDTH-1];
    a_mag = a_neg ? (~a_i + 1'b1) : a_i;
    b_mag = b_neg ? (~b_i + 1'b1) : b_i;
    // Remainder follows the dividend; everything else follows the sign product
    start_neg = (op_i[2] && op_i[1]) ? a_neg : (a_neg ^ b_neg);
  end

  // One iteration step
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   iter_hi, iter_lo;
  logic [2*WIDTH-1:0] full, full_fix;
  logic [WIDTH-1:0]   mul_res;

  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});

`ifdef ITER_ALU_DIV_EN
  logic [WIDTH:0]   div_shift, div_diff;
  logic             q_bit;
  logic [WIDTH-1:0] div_sel, div_res;

  assign div_shift = {hi_q, lo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign q_bit     = ~div_diff[WIDTH];

  always_comb begin
    if (div_q) begin
      iter_hi = q_bit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      iter_lo = {lo_q[WIDTH-2:0], q_bit};
    end else begin
      iter_hi = mul_sum[WIDTH:1];
      iter_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  assign div_sel = mop_q[1] ? iter_hi : iter_lo;
  assign div_res = neg_q ? (~div_sel + 1'b1) : div_sel;
`else
  assign iter_hi = mul_sum[WIDTH:1];
  assign iter_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
`endif

  assign full     = {iter_hi, iter_lo};
  assign full_fix = neg_q ? (~full + 1'b1) : full;
  assign mul_res  = (mop_q == 2'b00) ? full_fix[WIDTH-1:0] : full_fix[2*WIDTH-1:WIDTH];

  // Next state and datapath
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    cnt_d   = cnt_q;
    mop_d   = mop_q;
    neg_d   = neg_q;
`ifdef ITER_ALU_DIV_EN
    div_d   = div_q;
`endif

    case (state_q)
      BUSY: begin
        hi_d  = iter_hi;
        lo_d  = iter_lo;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == (SHW+1)'(1)) begin
          state_d = DONE;
`ifdef ITER_ALU_DIV_EN
          res_d   = div_q ? div_res : mul_res;
`else
          res_d   = mul_res;
`endif
        end
      end
      DONE: begin
        if (ready_i) state_d = IDLE;
      end
      default: ;
    endcase

    // accept is only possible from IDLE or from DONE with ready_i
    if (accept) begin
      mop_d = op_i[1:0];
      neg_d = start_neg;
      cnt_d = (SHW+1)'(WIDTH);
      if (!op_i[4]) begin
        res_d   = base_res;
        state_d = DONE;
      end else if (op_i[2]) begin
`ifdef ITER_ALU_DIV_EN
        if (b_i == '0) begin
          res_d   = op_i[1] ? a_i : '1;
          state_d = DONE;
        end else if (~op_i[0] && (a_i == {1'b1, {(WIDTH-1){1'b0}}}) && (b_i == '1)) begin
          res_d   = op_i[1] ? '0 : a_i;
          state_d = DONE;
        end else begin
          hi_d    = '0;
          lo_d    = a_mag;
          opnd_d  = b_mag;
          div_d   = 1'b1;
          state_d = BUSY;
        end
`else
        res_d   = '0;
        state_d = DONE;
`endif
      end else begin
        hi_d    = '0;
        lo_d    = b_mag;
        opnd_d  = a_mag;
`ifdef ITER_ALU_DIV_EN
        div_d   = 1'b0;
`endif
        state_d = BUSY;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      res_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      cnt_q   <= '0;
      mop_q   <= '0;
      neg_q   <= 1'b0;
`ifdef ITER_ALU_DIV_EN
      div_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      cnt_q   <= cnt_d;
      mop_q   <= mop_d;
      neg_q   <= neg_d;
`ifdef ITER_ALU_DIV_EN
      div_q   <= div_d;
`endif
    end
  end

endmodule

// File: doc/iter_alu.md
# iter_alu

Parametrised, handshaked successor of the single-cycle RV32 ALU. It adds the RISC-V M-extension multiply, divide and remainder operations, computed iteratively one bit per cycle, alongside the existing base ops. Base ops complete with one registered cycle of latency. The block sits in the execute stage and stalls the pipeline through a valid/ready handshake on both sides.

## Interface
- `WIDTH`, default 32: datapath width. Must be a power of two, ≥ 8.
- `SHW`, default `$clog2(WIDTH)`: shift-amount width. Derived; do not override.

Ports:
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `valid_i` in 1: operation request.
- `ready_o` out 1: block can accept a request this cycle.
- `op_i` in 5: operation select.
- `a_i` in WIDTH: operand A.
- `b_i` in WIDTH: operand B.
- `valid_o` out 1: result valid.
- `ready_i` in 1: consumer accepts the result.
- `res_o` out WIDTH: result.
- `busy_o` out 1: iterative operation in progress.

One clock; reset is asynchronous and active-high.

## Operation

Base ops, `op_i[4]=0` (same encodings as the existing ALU):
- 0000 add; 1100 sub.
- 0001 sll, 0101 srl, 1101 sra. Shift amount is `b_i[SHW-1:0]`.
- 0010 slt (signed); 0011 sltu. Result is zero-extended 0 or 1.
- 0100 xor, 0110 or, 0111 and.
- 1111 pass B.
- Any other encoding returns 0.

M ops, `op_i[4]=1`:
- 10000 MUL: low WIDTH bits of the product.
- 10001 MULH: high bits, signed×signed.
- 10010 MULHSU: high bits, signed A × unsigned B.
- 10011 MULHU: high bits, unsigned×unsigned.
- 10100 DIV, 10101 DIVU: quotient.
- 10110 REM, 10111 REMU: remainder.

Handshake and request capture:
- A request is accepted on a rising edge with `valid_i && ready_o`. `op_i`, `a_i` and `b_i` are captured at that edge.
- `ready_o = (state==IDLE) || (state==DONE && ready_i)`. This allows back-to-back ops with no bubble.

FSM:
- IDLE: on accept of a base op → DONE, with the result registered. On accept of an M op → BUSY, with the iteration counter set to WIDTH.
- BUSY: shift-add (multiply) or restoring shift-subtract (divide), one bit per cycle. The counter decrements each cycle. When it reaches 0, apply the sign fix-up and go to DONE.
- DONE: `valid_o=1`; `res_o` is held stable until `ready_i`. When `ready_i` is high: go to IDLE, or take the next request directly if `valid_i` is also high.

Signed M ops:
- Operands are converted to magnitudes at capture.
- The result is negated on exit when the operand signs require it. REM takes the sign of the dividend.

Divide special cases (fast path, handled like base ops, no BUSY state):
- Divide by zero: quotient = all ones; remainder = A.
- Signed overflow (A = most-negative, B = −1): quotient = A; remainder = 0.

`busy_o` is 1 exactly in BUSY.

## Timing
- Reset values: state IDLE, `valid_o=0`, `busy_o=0`, `res_o=0`, `ready_o=1`.
- Base op and divide fast path: `valid_o` rises in the cycle after the accepting edge (latency 1).
- Multiply/divide: `valid_o` rises WIDTH+1 cycles after the accepting edge (32-bit: 33).
- `valid_o`, once high, stays high with `res_o` constant until the edge where `ready_i=1`.
- `ready_i` has no effect outside DONE. `valid_i` is ignored while `ready_o=0`.
- Reset asserted mid-BUSY or mid-DONE: immediate (asynchronous) return to reset values; the in-flight result is discarded.
- Continuous `valid_i` and `ready_i` with base ops: one result per cycle.

## Configuration
- `ITER_ALU_DIV_EN` defined: divide/remainder datapath is compiled in, behaving as described above.
- Not defined: no divider hardware is built.
  - Ops 10100–10111 complete with latency 1 and `res_o=0`.
  - MUL ops are unaffected.

## Test plan
- Reset then idle: `rst_i` high for 2 cycles → `valid_o=0`, `res_o=0`, `ready_o=1`. Then op 1101 with A=0x80000000, B=4 → next cycle `res_o=0xF8000000`.
- Back-to-back base ops, `ready_i` held 1: add 5+7, sub 3−5, sltu 1<0xFFFFFFFF on consecutive cycles → results 12, 0xFFFFFFFE, 1 on consecutive cycles.
- MULH with A=0xFFFFFFFF (−1), B=2 → `valid_o` rises 33 cycles after accept with `res_o=0xFFFFFFFF`; `busy_o` high for 32 cycles. MUL with the same operands → 0xFFFFFFFE.
- Divide, with `ITER_ALU_DIV_EN` defined:
  - DIV −7/2 → −3 (0xFFFFFFFD); REM −7/2 → −1.
  - DIVU 7/0 → 0xFFFFFFFF at latency 1.
  - DIV 0x80000000/−1 → 0x80000000; REM of the same → 0.
- Backpressure: complete MUL with `ready_i=0` for 5 cycles → `res_o` stable and `ready_o=0` throughout. Raise `ready_i` with `valid_i` set to a new add → new request accepted on that same edge.
- Reset mid-BUSY: assert `rst_i` 10 cycles into DIVU → `busy_o` and `valid_o` go to 0 without waiting for a clock edge. A following add 1+1 returns 2 at latency 1.
